// File: rtl/pipe_ctrl_pkg.sv
// Shared hold encodings and bus widths for the pipeline controller.
package pipe_ctrl_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_IF   = 3'd2;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam logic [XLEN-1:0] STALL_MAX = {XLEN{1'b1}};

    localparam logic [1:0] DRAIN_LOAD = 2'd2;
endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush control with a debug halt FSM and
// a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] STALL_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_flag_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            hold_flag_ex_i,
    input  logic            hold_flag_rib_i,
    input  logic            jtag_halt_req_i,
    input  logic            jtag_resume_req_i,
    output logic [2:0]      hold_flag_o,
    output logic            jump_flag_o,
    output logic [XLEN-1:0] jump_addr_o,
    output logic            jtag_halted_o,
    output logic [XLEN-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED,
        RESUME
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic [1:0] drain_q;
    logic [1:0] drain_d;
    logic       stall_inc;
    logic       busy;

    assign busy = jump_flag_i | hold_flag_ex_i;

    always_comb begin
        hold_flag_o = HOLD_NONE;
        jump_flag_o = 1'b0;
        jump_addr_o = '0;
        if (rst) begin
            unique case (state_q)
                RUN: begin
                    jump_flag_o = jump_flag_i;
                    jump_addr_o = jump_addr_i;
                    if (busy)
                        hold_flag_o = HOLD_ID;
                    else if (hold_flag_rib_i)
                        hold_flag_o = HOLD_PC;
                end
                DRAIN: begin
                    jump_flag_o = jump_flag_i;
                    jump_addr_o = jump_addr_i;
                    hold_flag_o = busy ? HOLD_ID : HOLD_PC;
                end
                HALTED: hold_flag_o = HOLD_ID;
                RESUME: begin
                    jump_flag_o = jump_flag_i;
                    jump_addr_o = jump_addr_i;
                end
                default: hold_flag_o = HOLD_NONE;
            endcase
        end
    end

    // Drain only counts down on cycles where nothing is in flight.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            RUN: begin
                if (jtag_halt_req_i) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (jump_flag_i) begin
                    drain_d = DRAIN_LOAD;
                end else if (!hold_flag_ex_i && !hold_flag_rib_i) begin
                    if (drain_q == 2'd1) begin
                        state_d = HALTED;
                        drain_d = 2'd0;
                    end else begin
                        drain_d = drain_q - 2'd1;
                    end
                end
            end
            HALTED: begin
                if (jtag_resume_req_i)
                    state_d = RESUME;
            end
            RESUME: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign stall_inc = (hold_flag_o != HOLD_NONE) &&
                       (state_q == RUN || state_q == DRAIN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            drain_q       <= 2'd0;
            jtag_halted_o <= 1'b0;
            stall_cnt_o   <= STALL_RST;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            jtag_halted_o <= (state_d == HALTED);
            if (stall_inc && stall_cnt_o != STALL_MAX)
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized scoreboard bench for pipe_ctrl: a behavioural model
// predicts each cycle, a monitor compares on the falling edge.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [31:0] SAT_RST = 32'hFFFF_FFFD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jf = 1'b0;
    logic [31:0] ja = '0;
    logic        ex = 1'b0;
    logic        rib = 1'b0;
    logic        hreq = 1'b0;
    logic        rreq = 1'b0;

    logic [2:0]  hold_a, hold_b;
    logic        jfo_a, jfo_b;
    logic [31:0] jao_a, jao_b;
    logic        hlt_a, hlt_b;
    logic [31:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jf), .jump_addr_i(ja),
        .hold_flag_ex_i(ex), .hold_flag_rib_i(rib),
        .jtag_halt_req_i(hreq), .jtag_resume_req_i(rreq),
        .hold_flag_o(hold_a), .jump_flag_o(jfo_a),
        .jump_addr_o(jao_a), .jtag_halted_o(hlt_a),
        .stall_cnt_o(cnt_a)
    );

    pipe_ctrl #(.STALL_RST(SAT_RST)) dut_sat (
        .clk(clk), .rst(rst),
        .jump_flag_i(jf), .jump_addr_i(ja),
        .hold_flag_ex_i(ex), .hold_flag_rib_i(rib),
        .jtag_halt_req_i(hreq), .jtag_resume_req_i(rreq),
        .hold_flag_o(hold_b), .jump_flag_o(jfo_b),
        .jump_addr_o(jao_b), .jtag_halted_o(hlt_b),
        .stall_cnt_o(cnt_b)
    );

    typedef struct {
        logic [2:0]  hold;
        logic        jf;
        logic [31:0] ja;
        logic        halted;
        logic [31:0] cnt;
        logic [31:0] cnt_s;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Model: halted / resuming flags, cycles of drain still owed.
    bit          m_halted = 0;
    bit          m_resuming = 0;
    int          m_drain_left = 0;
    logic [31:0] m_cnt = '0;
    logic [31:0] m_cnt_s = SAT_RST;

    function automatic logic [31:0] inc_sat(logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic cyc(bit r, bit j, logic [31:0] a, bit e, bit b,
                       bit h, bit s);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; jf = j; ja = a; ex = e; rib = b; hreq = h; rreq = s;
        x.halted = m_halted;
        x.cnt    = m_cnt;
        x.cnt_s  = m_cnt_s;
        x.jf     = 1'b0;
        x.ja     = '0;
        x.hold   = HOLD_NONE;
        if (r) begin
            if (m_halted) begin
                x.hold = HOLD_ID;
            end else begin
                x.jf = j;
                x.ja = a;
                if (m_resuming)
                    x.hold = HOLD_NONE;
                else if (j || e)
                    x.hold = HOLD_ID;
                else if (m_drain_left > 0 || b)
                    x.hold = HOLD_PC;
            end
        end
        exp_q.push_back(x);
        if (!r) begin
            m_halted = 0; m_resuming = 0; m_drain_left = 0;
            m_cnt = '0; m_cnt_s = SAT_RST;
        end else begin
            if (x.hold != HOLD_NONE && !m_halted && !m_resuming) begin
                m_cnt   = inc_sat(m_cnt);
                m_cnt_s = inc_sat(m_cnt_s);
            end
            if (m_halted) begin
                if (s) begin
                    m_halted = 0;
                    m_resuming = 1;
                end
            end else if (m_resuming) begin
                m_resuming = 0;
            end else if (m_drain_left > 0) begin
                if (j)
                    m_drain_left = 2;
                else if (!e && !b) begin
                    m_drain_left--;
                    if (m_drain_left == 0)
                        m_halted = 1;
                end
            end else if (h) begin
                m_drain_left = 2;
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            cyc(1, 0, '0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("hold_flag_o", {29'd0, hold_a}, {29'd0, x.hold});
            chk("jump_flag_o", {31'd0, jfo_a}, {31'd0, x.jf});
            chk("jump_addr_o", jao_a, x.ja);
            chk("jtag_halted_o", {31'd0, hlt_a}, {31'd0, x.halted});
            chk("stall_cnt_o", cnt_a, x.cnt);
            chk("sat_hold", {29'd0, hold_b}, {29'd0, x.hold});
            chk("sat_jump", {31'd0, jfo_b}, {31'd0, x.jf});
            chk("sat_addr", jao_b, x.ja);
            chk("sat_halted", {31'd0, hlt_b}, {31'd0, x.halted});
            chk("sat_stall_cnt", cnt_b, x.cnt_s);
        end
    end

    initial begin
        cyc(0, 0, '0, 0, 0, 0, 0);
        cyc(0, 1, 32'h55, 1, 1, 1, 0);
        idle(1);
        // Bus stall for three cycles.
        for (int i = 0; i < 3; i++)
            cyc(1, 0, '0, 0, 1, 0, 0);
        idle(1);
        cyc(1, 1, 32'h100, 0, 1, 0, 0);
        idle(1);
        // Clean halt, then resume.
        cyc(1, 0, '0, 0, 0, 1, 1);
        idle(4);
        cyc(1, 0, '0, 0, 0, 1, 1);
        idle(2);
        // Halt while a divide is running.
        cyc(1, 0, '0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            cyc(1, 0, '0, 1, 0, 0, 0);
        idle(3);
        cyc(1, 0, '0, 0, 0, 0, 1);
        idle(2);
        // Jump mid-drain restarts it.
        cyc(1, 0, '0, 0, 0, 1, 0);
        idle(1);
        cyc(1, 1, 32'hABC0, 0, 0, 0, 0);
        idle(3);
        cyc(1, 0, '0, 0, 0, 1, 1);
        idle(2);
        // Reset in the middle of a drain.
        cyc(1, 0, '0, 0, 0, 1, 0);
        idle(1);
        cyc(0, 0, '0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 7) == 0, $urandom,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) == 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain_queue actual=%0d required=0",
                     exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
